// File: rtl/health_tracker.sv
// ============================================================================
// health_tracker
// ----------------------------------------------------------------------------
// Per-player health state machine that sits upstream of the health-bar
// renderer. Registered hit strobes from the collision/scoring logic reduce a
// saturating health count. A non-fatal hit starts an invulnerability window,
// and a fatal hit parks the player in DEAD until a new round or a reset.
//
// Optional feature (compile-time macro HEALTH_REGEN_EN):
//   When this macro is defined, health regenerates by +1 after every
//   REGEN_CYCLES consecutive idle cycles in ALIVE while below MAX_HEALTH.
//   When it is not defined, health rises only through new_round_in or rst_in.
//
// Parameters
//   MAX_HEALTH     full/reset health. Legal values are 1..5, which keeps the
//                  renderer's bar length (health*40 px) at or below 200 px.
//   INVULN_CYCLES  length of the post-hit invulnerability window, in cycles.
//   REGEN_CYCLES   idle cycles per +1 health. Used only with HEALTH_REGEN_EN.
//
// Ports
//   clk_in         in   1  pixel clock; the only clock
//   rst_in         in   1  synchronous, active-high reset
//   hit_in         in   1  single-cycle hit strobe
//   damage_in      in   3  damage of the hit; sampled only when hit_in=1
//   new_round_in   in   1  single-cycle strobe; restores full health
//   health_out     out  3  current health, 0..MAX_HEALTH
//   invuln_out     out  1  high while invulnerable
//   dead_out       out  1  high while dead
//   hit_pulse_out  out  1  one-cycle pulse when a hit was applied
//
// All outputs are registered, so each input event shows up one cycle later.
// ============================================================================
module health_tracker #(
   parameter int MAX_HEALTH    = 5,
   parameter int INVULN_CYCLES = 37_125_000,
   parameter int REGEN_CYCLES  = 148_500_000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       hit_in,
   input  logic [2:0] damage_in,
   input  logic       new_round_in,
   output logic [2:0] health_out,
   output logic       invuln_out,
   output logic       dead_out,
   output logic       hit_pulse_out
);

   // A single-cycle window would give $clog2(1) = 0, so the timer is kept at
   // least 1 bit wide.
   localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(INVULN_CYCLES - 1);
   localparam logic [2:0]         HEALTH_FULL = 3'(MAX_HEALTH);

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] inv_timer;
   logic               hit_applies;
   logic [2:0]         hit_health;

   // Subtract damage with a floor at 0. A large hit never wraps the 3-bit
   // count back up to a high health value.
   function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
      return (a >= b) ? (a - b) : 3'd0;
   endfunction

`ifdef HEALTH_REGEN_EN
   localparam int REGEN_W = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;
   localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_CYCLES - 1);

   logic [REGEN_W-1:0] regen_cnt;

   // Increment health, clamped at full health.
   function automatic logic [2:0] sat_inc(input logic [2:0] a);
      return (a >= HEALTH_FULL) ? HEALTH_FULL : (a + 3'd1);
   endfunction
`endif

   // A hit is applied only in ALIVE and only with non-zero damage. A hit that
   // arrives together with new_round_in is dropped.
   always_comb begin
      hit_applies = hit_in && (damage_in != 3'd0) && (state == ALIVE) && !new_round_in;
      hit_health  = sat_sub(health_out, damage_in);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= ALIVE;
         health_out    <= HEALTH_FULL;
         invuln_out    <= 1'b0;
         dead_out      <= 1'b0;
         hit_pulse_out <= 1'b0;
         inv_timer     <= '0;
`ifdef HEALTH_REGEN_EN
         regen_cnt     <= '0;
`endif
      end else begin
         hit_pulse_out <= 1'b0;
         if (new_round_in) begin
            state      <= ALIVE;
            health_out <= HEALTH_FULL;
            invuln_out <= 1'b0;
            dead_out   <= 1'b0;
            inv_timer  <= '0;
`ifdef HEALTH_REGEN_EN
            regen_cnt  <= '0;
`endif
         end else begin
            case (state)
               ALIVE: begin
                  if (hit_applies) begin
                     hit_pulse_out <= 1'b1;
                     health_out    <= hit_health;
`ifdef HEALTH_REGEN_EN
                     regen_cnt     <= '0;
`endif
                     if (hit_health == 3'd0) begin
                        state    <= DEAD;
                        dead_out <= 1'b1;
                     end else begin
                        state      <= INVULN;
                        invuln_out <= 1'b1;
                        inv_timer  <= TIMER_LOAD;
                     end
                  end
`ifdef HEALTH_REGEN_EN
                  // The counter runs only while health is below full. The
                  // tick resets the counter together with the increment.
                  else if (health_out >= HEALTH_FULL) begin
                     regen_cnt <= '0;
                  end else if (regen_cnt == REGEN_LAST) begin
                     health_out <= sat_inc(health_out);
                     regen_cnt  <= '0;
                  end else begin
                     regen_cnt <= regen_cnt + 1'b1;
                  end
`endif
               end

               INVULN: begin
                  // The timer is loaded with N-1 and the state leaves on the
                  // cycle that sees 0, so the window is exactly N cycles long.
                  if (inv_timer == '0) begin
                     state      <= ALIVE;
                     invuln_out <= 1'b0;
                  end else begin
                     inv_timer <= inv_timer - 1'b1;
                  end
               end

               DEAD: begin
                  health_out <= 3'd0;
               end

               default: begin
                  state      <= ALIVE;
                  invuln_out <= 1'b0;
                  dead_out   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;

   localparam int MAXH   = 5;
   localparam int INV    = 8;
   localparam int REGEN  = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hit = 1'b0;
   logic [2:0] dmg = 3'd0;
   logic       nr  = 1'b0;
   logic [2:0] health_out;
   logic       invuln_out;
   logic       dead_out;
   logic       hit_pulse_out;

   int checks = 0;
   int errors = 0;

   health_tracker #(
      .MAX_HEALTH   (MAXH),
      .INVULN_CYCLES(INV),
      .REGEN_CYCLES (REGEN)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .hit_in       (hit),
      .damage_in    (dmg),
      .new_round_in (nr),
      .health_out   (health_out),
      .invuln_out   (invuln_out),
      .dead_out     (dead_out),
      .hit_pulse_out(hit_pulse_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. Invulnerability is tracked as "cycles still
   // remaining", death as a flag, and regen as a count of idle cycles spent
   // below full health.
   int m_h = 0, m_left = 0, m_idle = 0;
   bit m_dead = 0, m_pulse = 0, m_valid = 0;

   initial forever begin
      @(posedge clk);
      if (rst || nr) begin
         m_h = MAXH; m_left = 0; m_idle = 0; m_dead = 0; m_pulse = 0;
         if (rst) m_valid = 1;
      end else if (m_dead) begin
         m_pulse = 0;
      end else if (m_left > 0) begin
         m_left--; m_pulse = 0; m_idle = 0;
      end else if (hit && dmg != 0) begin
         m_h = (m_h >= int'(dmg)) ? m_h - int'(dmg) : 0;
         m_pulse = 1; m_idle = 0;
         if (m_h == 0) m_dead = 1;
         else m_left = INV;
      end else begin
         m_pulse = 0;
`ifdef HEALTH_REGEN_EN
         if (m_h < MAXH) begin
            m_idle++;
            if (m_idle == REGEN) begin m_h++; m_idle = 0; end
         end else m_idle = 0;
`endif
      end
   end

   // Compare the DUT against the model on every cycle once reset is seen.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("model_health", int'(health_out), m_h);
         check("model_invuln", int'(invuln_out), int'(m_left > 0));
         check("model_dead",   int'(dead_out),   int'(m_dead));
         check("model_pulse",  int'(hit_pulse_out), int'(m_pulse));
      end
   end

   task automatic step(input logic h, input logic [2:0] d, input logic n, input logic r);
      hit = h; dmg = d; nr = n; rst = r;
      @(negedge clk);
      hit = 1'b0; dmg = 3'd0; nr = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic wait_invuln_clear();
      for (int i = 0; i < 20 && invuln_out; i++) idle(1);
      check("invuln_cleared", int'(invuln_out), 0);
   endtask

   int n_inv;

   initial begin
      // 1. reset for two cycles
      step(1'b0, 3'd0, 1'b0, 1'b1);
      step(1'b0, 3'd0, 1'b0, 1'b1);
      check("rst_health", int'(health_out), 5);
      check("rst_invuln", int'(invuln_out), 0);
      check("rst_dead",   int'(dead_out), 0);
      check("rst_pulse",  int'(hit_pulse_out), 0);
      idle(1);

      // zero-damage hit is ignored
      step(1'b1, 3'd0, 1'b0, 1'b0);
      check("dmg0_health", int'(health_out), 5);
      check("dmg0_pulse",  int'(hit_pulse_out), 0);

      // 2. damage 2, then an ignored hit inside the window
      step(1'b1, 3'd2, 1'b0, 1'b0);
      check("hit2_health", int'(health_out), 3);
      check("hit2_pulse",  int'(hit_pulse_out), 1);
      check("hit2_invuln", int'(invuln_out), 1);
      n_inv = invuln_out ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         if (invuln_out) n_inv++;
      end
      check("hit2_pulse_gone", int'(hit_pulse_out), 0);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      if (invuln_out) n_inv++;
      check("inv_hit_health", int'(health_out), 3);
      check("inv_hit_pulse",  int'(hit_pulse_out), 0);
      for (int i = 0; i < 20 && invuln_out; i++) begin
         idle(1);
         if (invuln_out) n_inv++;
      end
      check("invuln_len", n_inv, 8);

      // 3. fatal hit with floor at 0, then hits while dead, then new round
      step(1'b1, 3'd7, 1'b0, 1'b0);
      check("fatal_health", int'(health_out), 0);
      check("fatal_dead",   int'(dead_out), 1);
      check("fatal_invuln", int'(invuln_out), 0);
      step(1'b1, 3'd3, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      check("dead_hit_health", int'(health_out), 0);
      check("dead_hit_pulse",  int'(hit_pulse_out), 0);
      check("dead_hold",       int'(dead_out), 1);
      step(1'b0, 3'd0, 1'b1, 1'b0);
      check("nr_health", int'(health_out), 5);
      check("nr_dead",   int'(dead_out), 0);

      // 4. new round and hit in the same cycle at health 4
      step(1'b1, 3'd1, 1'b0, 1'b0);
      check("h4_health", int'(health_out), 4);
      wait_invuln_clear();
      step(1'b1, 3'd3, 1'b1, 1'b0);
      check("nr_hit_health", int'(health_out), 5);
      check("nr_hit_pulse",  int'(hit_pulse_out), 0);
      check("nr_hit_invuln", int'(invuln_out), 0);

      // 5. regen from health 3
      step(1'b1, 3'd2, 1'b0, 1'b0);
      wait_invuln_clear();
      idle(15);
      check("regen_pre", int'(health_out), 3);
      idle(1);
`ifdef HEALTH_REGEN_EN
      check("regen_4", int'(health_out), 4);
      idle(16);
      check("regen_5", int'(health_out), 5);
      idle(20);
      check("regen_hold", int'(health_out), 5);
      step(1'b1, 3'd2, 1'b0, 1'b0);
      wait_invuln_clear();
      idle(15);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      check("tick_hit_health", int'(health_out), 2);
      check("tick_hit_pulse",  int'(hit_pulse_out), 1);
`else
      check("noregen_16", int'(health_out), 3);
      idle(40);
      check("noregen_56", int'(health_out), 3);
`endif

      // 6. reset in the middle of the window, then an immediate hit
      step(1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      idle(2);
      check("pre_rst_invuln", int'(invuln_out), 1);
      step(1'b0, 3'd0, 1'b0, 1'b1);
      check("mid_rst_health", int'(health_out), 5);
      check("mid_rst_invuln", int'(invuln_out), 0);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      check("post_rst_health", int'(health_out), 4);
      check("post_rst_pulse",  int'(hit_pulse_out), 1);
      check("post_rst_invuln", int'(invuln_out), 1);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
